// File: rtl/magma_key_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : magma_key_sched_if
// Purpose  : Bundles the key-load handshake, sequence control, key-storage
//            bus and round-key handshake of the Magma key scheduler.
// Ports    : master - the key scheduler (drives key_ready, ks_*, round_*)
//            slave  - the surrounding system (key source, RAM, round stage)
// Revision : 1.0 - initial release
// ============================================================================
interface magma_key_sched_if #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] key_word;
  logic              key_valid;
  logic              key_ready;
  logic              start;
  logic              decrypt;
  logic              ks_enable;
  logic              ks_we;
  logic [ADDR_W-1:0] ks_addr;
  logic [WORD_W-1:0] ks_wdata;
  logic [WORD_W-1:0] ks_rdata;
  logic [WORD_W-1:0] round_key;
  logic              rk_valid;
  logic              rk_ready;
  logic [4:0]        round_idx;
  logic              busy;
  logic              done;

  modport master (
    input  key_word, key_valid, start, decrypt, ks_rdata, rk_ready,
    output key_ready, ks_enable, ks_we, ks_addr, ks_wdata,
           round_key, rk_valid, round_idx, busy, done
  );

  modport slave (
    output key_word, key_valid, start, decrypt, ks_rdata, rk_ready,
    input  key_ready, ks_enable, ks_we, ks_addr, ks_wdata,
           round_key, rk_valid, round_idx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/magma_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : magma_key_sched
// Purpose  : Loads a 256-bit Magma key (eight 32-bit words K0..K7) into an
//            external key storage, then replays the 32 round keys in
//            encrypt or decrypt order, one per HOLD/rk_ready handshake.
// Ports    : clk   - single clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - magma_key_sched_if.master (key load, start/decrypt,
//                    key-storage bus, round-key handshake, busy/done)
// Revision : 1.0 - initial release
// ============================================================================
module magma_key_sched #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  magma_key_sched_if.master   bus
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_LOAD = 3'd1;
  localparam logic [2:0] c_ST_READ = 3'd2;
  localparam logic [2:0] c_ST_WAIT = 3'd3;
  localparam logic [2:0] c_ST_HOLD = 3'd4;
  localparam logic [2:0] c_ST_DONE = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;

  logic [3:0]        r_cnt;         // words accepted in the current load
  logic              r_last_wr;     // eighth word is being written this cycle
  logic              r_key_loaded;
  logic [4:0]        r_round;
  logic              r_decrypt;

  logic              r_ks_en;
  logic              r_ks_we;
  logic [ADDR_W-1:0] r_ks_addr;
  logic [WORD_W-1:0] r_ks_wdata;
  logic [WORD_W-1:0] r_round_key;
  logic [4:0]        r_round_idx;
  logic              r_rk_valid;

  logic              w_key_ready;
  logic              w_key_hs;
  logic              w_start_ok;
  logic              w_rk_hs;
  logic [2:0]        w_wr_slot;
  logic [2:0]        w_rd_idx;
  logic              w_ks_en_nxt;
  logic              w_ks_we_nxt;
  logic [ADDR_W-1:0] w_ks_addr_nxt;
  logic [WORD_W-1:0] w_ks_wdata_nxt;

  assign w_key_ready = (r_state == c_ST_IDLE) || (r_state == c_ST_LOAD);
  assign w_key_hs    = bus.key_valid && w_key_ready;
  // A new key load takes precedence over a start arriving in the same cycle.
  assign w_start_ok  = (r_state == c_ST_IDLE) && bus.start && r_key_loaded && !w_key_hs;
  assign w_rk_hs     = (r_state == c_ST_HOLD) && bus.rk_ready;

  // The count still holds 8 after a completed load, so the first word of a
  // new load is forced into slot 0.
  assign w_wr_slot = (r_state == c_ST_IDLE) ? 3'd0 : r_cnt[2:0];

  // Encrypt: K0..K7 three times, then K7..K0.
  // Decrypt: K0..K7 once, then K7..K0 three times.
  always_comb begin
    w_rd_idx = r_round[2:0];
    if (r_decrypt) begin
      if (r_round >= 5'd8) w_rd_idx = 3'd7 - r_round[2:0];
    end else begin
      if (r_round >= 5'd24) w_rd_idx = 3'd7 - r_round[2:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_key_hs)        w_state_nxt = c_ST_LOAD;
        else if (w_start_ok) w_state_nxt = c_ST_READ;
      end
      c_ST_LOAD: begin
        if (w_key_hs && (r_cnt == 4'd7)) w_state_nxt = c_ST_IDLE;
      end
      c_ST_READ: w_state_nxt = c_ST_WAIT;
      c_ST_WAIT: w_state_nxt = c_ST_HOLD;
      c_ST_HOLD: begin
        if (w_rk_hs) w_state_nxt = (r_round == 5'd31) ? c_ST_DONE : c_ST_READ;
      end
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic: next value of the registered key-storage strobes.
  // Strobes are single-cycle; anything other than a write or read drops them.
  always_comb begin
    w_ks_en_nxt    = 1'b0;
    w_ks_we_nxt    = 1'b0;
    w_ks_addr_nxt  = '0;
    w_ks_wdata_nxt = '0;
    if (w_key_hs) begin
      w_ks_en_nxt    = 1'b1;
      w_ks_we_nxt    = 1'b1;
      w_ks_addr_nxt  = ADDR_W'(w_wr_slot);
      w_ks_wdata_nxt = bus.key_word;
    end else if (r_state == c_ST_READ) begin
      w_ks_en_nxt    = 1'b1;
      w_ks_addr_nxt  = ADDR_W'(w_rd_idx);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 4'd0;
      r_last_wr    <= 1'b0;
      r_key_loaded <= 1'b0;
      r_round      <= 5'd0;
      r_decrypt    <= 1'b0;
      r_ks_en      <= 1'b0;
      r_ks_we      <= 1'b0;
      r_ks_addr    <= '0;
      r_ks_wdata   <= '0;
      r_round_key  <= '0;
      r_round_idx  <= 5'd0;
      r_rk_valid   <= 1'b0;
    end else begin
      r_ks_en    <= w_ks_en_nxt;
      r_ks_we    <= w_ks_we_nxt;
      r_ks_addr  <= w_ks_addr_nxt;
      r_ks_wdata <= w_ks_wdata_nxt;

      r_last_wr <= w_key_hs && (r_state == c_ST_LOAD) && (r_cnt == 4'd7);

      if (w_key_hs) begin
        r_cnt <= (r_state == c_ST_IDLE) ? 4'd1 : (r_cnt + 4'd1);
      end

      // key_loaded rises together with the eighth write strobe's cycle end.
      if (w_key_hs && (r_state == c_ST_IDLE)) r_key_loaded <= 1'b0;
      else if (r_last_wr)                      r_key_loaded <= 1'b1;

      if (w_start_ok) begin
        r_round   <= 5'd0;
        r_decrypt <= bus.decrypt;
      end else if (w_rk_hs && (r_round != 5'd31)) begin
        r_round <= r_round + 5'd1;
      end

      if (r_state == c_ST_WAIT) begin
        r_round_key <= bus.ks_rdata;
        r_round_idx <= r_round;
        r_rk_valid  <= 1'b1;
      end else if (w_rk_hs) begin
        r_rk_valid  <= 1'b0;
      end
    end
  end

  assign bus.key_ready = w_key_ready;
  assign bus.ks_enable = r_ks_en;
  assign bus.ks_we     = r_ks_we;
  assign bus.ks_addr   = r_ks_addr;
  assign bus.ks_wdata  = r_ks_wdata;
  assign bus.round_key = r_round_key;
  assign bus.round_idx = r_round_idx;
  assign bus.rk_valid  = r_rk_valid;
  assign bus.busy      = (r_state == c_ST_LOAD) || (r_state == c_ST_READ) ||
                         (r_state == c_ST_WAIT) || (r_state == c_ST_HOLD);
  assign bus.done      = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
